// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses and optional FWFT read.
// Read latency is one edge for standard mode and zero for FWFT. Writes are rejected when full unless a read pops in the same cycle.
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_ok, wr_ok;

  // Every flag is decoded from the registered count so they all move together.
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign data_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_ok       = rd_en & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr_ok       = wr_en & (~fifo_full | rd_ok);
    wr_ptr_d    = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
    overflow_d  = wr_en & ~wr_ok;
    underflow_d = rd_en & ~rd_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    // Nonblocking read of the same slot being written when full yields the old word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= mem_q[rd_ptr_q];
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-read and an FWFT instance with identical stimulus and checks both against a queue model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout0, dout1;
  logic       emp0, emp1, ful0, ful1, af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [4:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] exp_d0 = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(12), .AE_THRESH(4)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .fifo_empty(emp0), .fifo_full(ful0), .almost_full(af0),
    .almost_empty(ae0), .data_count(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(12), .AE_THRESH(4)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .fifo_empty(emp1), .fifo_full(ful1), .almost_full(af1),
    .almost_empty(ae1), .data_count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] e1;
    n  = q.size();
    e1 = (n == 0) ? 8'h00 : q[0];
    chk("count_std", cnt0, n);
    chk("count_fwft", cnt1, n);
    chk("empty_std", emp0, n == 0);
    chk("empty_fwft", emp1, n == 0);
    chk("full_std", ful0, n == DEPTH);
    chk("full_fwft", ful1, n == DEPTH);
    chk("afull_std", af0, n >= 12);
    chk("afull_fwft", af1, n >= 12);
    chk("aempty_std", ae0, n <= 4);
    chk("aempty_fwft", ae1, n <= 4);
    chk("ovf_std", ovf0, exp_ovf);
    chk("ovf_fwft", ovf1, exp_ovf);
    chk("udf_std", udf0, exp_udf);
    chk("udf_fwft", udf1, exp_udf);
    chk("dout_std", dout0, exp_d0);
    chk("dout_fwft", dout1, e1);
  endtask

  task automatic model_reset();
    q.delete();
    exp_d0  = 8'h00;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  // One clock with the given request; the model applies the acceptance rules to pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    int  n;
    bit  rok, wok;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    n   = q.size();
    rok = r && (n > 0);
    wok = w && ((n < DEPTH) || rok);
    if (rok) exp_d0 = q.pop_front();
    if (wok) q.push_back(d);
    exp_ovf = w && !wok;
    exp_udf = r && !rok;
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    #2;
    model_reset();
    check_all();
    #5 rst = 1'b0;

    // Fill with 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));

    // Overflow attempt from full, then idle to see the pulse drop
    step(1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b0, 8'h00);

    // Drain in order, then one read too many
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Simultaneous read/write on empty
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Fill with random data, then streaming read+write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // Random traffic, write-biased then read-biased to cross both boundaries
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 8'($urandom));
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));

    // Asynchronous reset in the middle of a burst at count 9
    step(1'b0, 1'b0, 8'h00);
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    wr_en = 1'b1;
    data_in = 8'hEE;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    step(1'b1, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'h4D);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
